rf_repair_writer: RTL and testbench

//  Owns the register-file write port. Merges WB-stage result writes with repair writes for

---
 rtl/rf_repair_writer_pkg.sv | 15 +
 rtl/rf_repair_writer_secded_encoder.sv | 26 ++
 rtl/rf_repair_writer.sv | 129 ++++++++++++
 tb/tb_rf_repair_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_repair_writer_pkg.sv
// Shared types for the register-file repair writer: RF address, check-bit width
// and the repair-queue entry layout.
package rf_repair_writer_pkg;
    localparam int RF_ADD_W  = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_CHK_W  = 7;

    typedef logic [RF_ADD_W-1:0] rf_add;

    typedef struct packed {
        logic                 valid;
        rf_add                add;
        logic [RF_DATA_W-1:0] val;
    } rep_entry_t;
endpackage

// File: rtl/rf_repair_writer_secded_encoder.sv
// SECDED encoder: Hamming(38,32) check bits [5:0] plus overall even parity in bit 6.
// Purely combinational; the RF-side decoder uses the same bit placement.
module secded_encoder
    import rf_repair_writer_pkg::*;
(
    input  logic [RF_DATA_W-1:0] data,
    output logic [RF_CHK_W-1:0]  chk
);
    // Data occupies the non-power-of-two codeword positions 3,5,6,7,9,...,38;
    // the Hamming syndrome of a codeword is the XOR of the positions of its set bits.
    function automatic logic [RF_CHK_W-1:0] encode(input logic [RF_DATA_W-1:0] d);
        logic [5:0] syn;
        int         j;
        syn = '0;
        j   = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[5'(j)]) syn = syn ^ 6'(p);
                j++;
            end
        end
        return {(^d) ^ (^syn), syn};
    endfunction

    assign chk = encode(data);
endmodule

// File: rtl/rf_repair_writer.sv
// Register-file write-port owner: WB writes take priority, buffered repair writes
// drain in free slots, and a starved repair raises a registered stall request.
module rf_repair_writer
    import rf_repair_writer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                         s_clk_i,
    input  logic                         s_reset_i,
    input  logic                         s_wb_we_i,
    input  rf_add                        s_wb_rd_i,
    input  logic [RF_DATA_W-1:0]         s_wb_val_i,
    input  logic [1:0]                   s_rep_valid_i,
    input  rf_add [1:0]                  s_rep_add_i,
    input  logic [1:0][RF_DATA_W-1:0]    s_rep_val_i,
    output logic                         s_rf_we_o,
    output rf_add                        s_rf_add_o,
    output logic [RF_DATA_W-1:0]         s_rf_val_o,
    output logic [RF_CHK_W-1:0]          s_rf_chk_o,
    output logic                         s_stall_o,
    output logic                         s_rep_drop_o,
    output logic [$clog2(DEPTH+1)-1:0]   s_rep_pend_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);

    logic [DEPTH-1:0]     q_valid;
    rf_add                q_add [DEPTH];
    logic [RF_DATA_W-1:0] q_val [DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr, wr_nxt;
    logic [CW-1:0]        count;
    logic [AW-1:0]        age, age_d;

    rep_entry_t           head;
    logic                 nonempty, wb_act, pop, write_head;
    logic                 hit0, hit1, cand0, cand1, acc0, acc1, drop_d;
    logic [1:0]           n_push;
    logic [CW:0]          free;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
        return (a == AW'(MAX_WAIT)) ? a : a + AW'(1);
    endfunction

    assign nonempty   = (count != '0);
    assign head.valid = nonempty && q_valid[rd_ptr];
    assign head.add   = q_add[rd_ptr];
    assign head.val   = q_val[rd_ptr];

    assign wb_act     = s_wb_we_i && (s_wb_rd_i != '0);
    // An invalidated head needs no write slot, so it retires even under WB traffic.
    assign pop        = nonempty && (!head.valid || !wb_act);
    assign write_head = head.valid && !wb_act;

    assign s_rf_we_o  = !s_reset_i && (wb_act || write_head);
    assign s_rf_add_o = wb_act ? s_wb_rd_i  : head.add;
    assign s_rf_val_o = wb_act ? s_wb_val_i : head.val;

    secded_encoder u_enc (
        .data (s_rf_val_o),
        .chk  (s_rf_chk_o)
    );

    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && q_add[i] == s_rep_add_i[0]) hit0 = 1'b1;
            if (q_valid[i] && q_add[i] == s_rep_add_i[1]) hit1 = 1'b1;
        end
    end

    assign cand0 = s_rep_valid_i[0] && (s_rep_add_i[0] != '0) && !hit0 &&
                   !(wb_act && s_rep_add_i[0] == s_wb_rd_i);
    assign cand1 = s_rep_valid_i[1] && (s_rep_add_i[1] != '0) && !hit1 &&
                   !(wb_act && s_rep_add_i[1] == s_wb_rd_i) &&
                   !(cand0 && s_rep_add_i[1] == s_rep_add_i[0]);

    // Free slots are counted after this cycle's pop.
    assign free   = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    assign acc0   = cand0 && (free != '0);
    assign acc1   = cand1 && (free > (CW+1)'(acc0));
    assign drop_d = (cand0 && !acc0) || (cand1 && !acc1);
    assign n_push = {1'b0, acc0} + {1'b0, acc1};
    assign wr_nxt = wr_ptr + PW'(1);

    always_comb begin
        if (!nonempty || pop) age_d = '0;
        else                  age_d = sat_inc(age);
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            q_valid      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            age          <= '0;
            s_stall_o    <= 1'b0;
            s_rep_drop_o <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wb_act && q_add[i] == s_wb_rd_i) q_valid[i] <= 1'b0;
            if (pop)          q_valid[rd_ptr] <= 1'b0;
            if (acc0 || acc1) q_valid[wr_ptr] <= 1'b1;
            if (acc0 && acc1) q_valid[wr_nxt] <= 1'b1;
            rd_ptr       <= rd_ptr + PW'(pop);
            wr_ptr       <= wr_ptr + PW'(n_push);
            count        <= count - CW'(pop) + CW'(n_push);
            age          <= age_d;
            s_stall_o    <= (age_d == AW'(MAX_WAIT));
            s_rep_drop_o <= drop_d;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (acc0 || acc1) begin
            q_add[wr_ptr] <= acc0 ? s_rep_add_i[0] : s_rep_add_i[1];
            q_val[wr_ptr] <= acc0 ? s_rep_val_i[0] : s_rep_val_i[1];
        end
        if (acc0 && acc1) begin
            q_add[wr_nxt] <= s_rep_add_i[1];
            q_val[wr_nxt] <= s_rep_val_i[1];
        end
    end

    assign s_rep_pend_o = count;
endmodule

// File: tb/tb_rf_repair_writer.sv
// Bench for rf_repair_writer: directed scenarios plus randomized traffic compared
// against a queue-based reference model of the write-port rules.
module tb_rf_repair_writer;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic [31:0]      wb_val = '0;
    logic [1:0]       rep_v = '0;
    logic [1:0][4:0]  rep_a = '0;
    logic [1:0][31:0] rep_d = '0;
    logic             rf_we, stall, drop;
    logic [4:0]       rf_add;
    logic [31:0]      rf_val;
    logic [6:0]       rf_chk;
    logic [2:0]       pend;

    rf_repair_writer #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .s_clk_i       (clk),
        .s_reset_i     (rst),
        .s_wb_we_i     (wb_we),
        .s_wb_rd_i     (wb_rd),
        .s_wb_val_i    (wb_val),
        .s_rep_valid_i (rep_v),
        .s_rep_add_i   (rep_a),
        .s_rep_val_i   (rep_d),
        .s_rf_we_o     (rf_we),
        .s_rf_add_o    (rf_add),
        .s_rf_val_o    (rf_val),
        .s_rf_chk_o    (rf_chk),
        .s_stall_o     (stall),
        .s_rep_drop_o  (drop),
        .s_rep_pend_o  (pend)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit        valid;
        bit [4:0]  add;
        bit [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_age   = 0;
    bit   m_stall = 1'b0;
    bit   m_drop  = 1'b0;

    logic        s_we;
    logic [4:0]  s_add;
    logic [31:0] s_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the 38-bit codeword explicitly, then takes each parity group.
    function automatic logic [6:0] ref_chk(input logic [31:0] d);
        bit cw [39];
        bit [6:0] c;
        int j;
        j = 0;
        for (int p = 0; p < 39; p++) cw[p] = 1'b0;
        for (int p = 1; p <= 38; p++)
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                cw[p] = d[j];
                j++;
            end
        c = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if ((p >> k) % 2 == 1) c[k] = c[k] ^ cw[p];
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    task automatic cyc(input bit we, input bit [4:0] rd, input bit [31:0] v,
                       input bit [1:0] rv, input bit [4:0] a0, input bit [31:0] d0,
                       input bit [4:0] a1, input bit [31:0] d1);
        bit wb, ewe, popped, waiting, hit0, hit1, c0, c1, dropped;
        bit [4:0]  eadd;
        bit [31:0] eval;
        wb_we = we; wb_rd = rd; wb_val = v;
        rep_v = rv; rep_a[0] = a0; rep_d[0] = d0; rep_a[1] = a1; rep_d[1] = d1;
        #4;
        wb = we && rd != 0;
        ewe = 1'b0; eadd = '0; eval = '0;
        if (wb) begin
            ewe = 1'b1; eadd = rd; eval = v;
        end else if (mq.size() > 0 && mq[0].valid) begin
            ewe = 1'b1; eadd = mq[0].add; eval = mq[0].val;
        end
        s_we = rf_we; s_add = rf_add; s_val = rf_val;
        check("rf_we", rf_we, ewe);
        if (ewe) begin
            check("rf_add", rf_add, eadd);
            check("rf_val", rf_val, eval);
            check("rf_chk", rf_chk, ref_chk(eval));
        end
        check("pend", pend, mq.size());
        check("stall", stall, m_stall);
        check("drop", drop, m_drop);
        hit0 = 1'b0; hit1 = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].valid && mq[i].add == a0) hit0 = 1'b1;
            if (mq[i].valid && mq[i].add == a1) hit1 = 1'b1;
        end
        popped  = mq.size() > 0 && (!mq[0].valid || !wb);
        waiting = mq.size() > 0 && !popped;
        if (popped) void'(mq.pop_front());
        if (wb) foreach (mq[i]) if (mq[i].add == rd) mq[i].valid = 1'b0;
        c0 = rv[0] && a0 != 0 && !hit0 && !(wb && a0 == rd);
        c1 = rv[1] && a1 != 0 && !hit1 && !(wb && a1 == rd) && !(c0 && a1 == a0);
        dropped = 1'b0;
        if (c0) begin
            if (mq.size() < DEPTH) mq.push_back('{1'b1, a0, d0});
            else dropped = 1'b1;
        end
        if (c1) begin
            if (mq.size() < DEPTH) mq.push_back('{1'b1, a1, d1});
            else dropped = 1'b1;
        end
        m_age   = waiting ? ((m_age < MAX_WAIT) ? m_age + 1 : MAX_WAIT) : 0;
        m_stall = (m_age == MAX_WAIT);
        m_drop  = dropped;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic busy(input bit [1:0] rv, input bit [4:0] a0, input bit [4:0] a1);
        cyc(1'b1, 5'd1, $urandom, rv, a0, $urandom, a1, $urandom);
    endtask

    initial begin
        wb_we = 1'b1; wb_rd = 5'd3; wb_val = 32'hdead_beef;
        repeat (2) @(posedge clk);
        #1;
        check("reset rf_we", rf_we, 1'b0);
        check("reset pend", pend, 0);
        check("reset stall", stall, 1'b0);
        check("reset drop", drop, 1'b0);
        rst = 1'b0;

        // Drain of a single repair with no WB traffic
        cyc(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'd0);
        check("T1 pend after push", pend, 1);
        idle();
        check("T1 we", s_we, 1'b1);
        check("T1 add", s_add, 5);
        check("T1 val", s_val, 32'h1234_5678);
        check("T1 pend after drain", pend, 0);

        // Starved repair behind continuous WB writes
        cyc(1'b1, 5'd3, 32'h3333_0000, 2'b01, 5'd7, 32'h7777_7777, 5'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 5'd3, 32'h3333_0000 + k, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
            if (k == 7) check("T2 stall before limit", stall, 1'b0);
        end
        check("T2 stall at limit", stall, 1'b1);
        cyc(1'b1, 5'd3, 32'h3333_0009, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("T2 wb keeps port", s_add, 3);
        idle();
        check("T2 repair add", s_add, 7);
        check("T2 repair val", s_val, 32'h7777_7777);
        check("T2 stall released", stall, 1'b0);

        // Stale repair invalidated by a newer WB write
        cyc(1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 32'h0909_0909, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 32'hAAAA_AAAA, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("T3 wb val", s_val, 32'hAAAA_AAAA);
        idle();
        check("T3 stale no write", s_we, 1'b0);
        check("T3 pend", pend, 0);

        // Queue full: both extra requests discarded in one pulse
        busy(2'b11, 5'd10, 5'd11);
        busy(2'b11, 5'd12, 5'd13);
        check("T4 pend full", pend, 4);
        busy(2'b11, 5'd14, 5'd15);
        check("T4 drop pulse", drop, 1'b1);
        check("T4 pend held", pend, 4);
        busy(2'b00, 5'd0, 5'd0);
        check("T4 drop cleared", drop, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("T4 drain order", s_add, 10 + k);
        end

        // Duplicate ports and x0 requests
        cyc(1'b1, 5'd1, 32'd1, 2'b11, 5'd4, 32'h4444_0000, 5'd4, 32'h4444_1111);
        check("T5 one entry", pend, 1);
        check("T5 no drop", drop, 1'b0);
        busy(2'b01, 5'd0, 5'd0);
        check("T5 x0 ignored", pend, 1);
        idle();
        check("T5 first port wins", s_val, 32'h4444_0000);
        idle();
        check("T5 nothing left", s_we, 1'b0);

        // Randomized traffic on a small address range to force collisions
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), $urandom);
        repeat (DEPTH) idle();

        // Asynchronous reset in the middle of a drain
        busy(2'b11, 5'd20, 5'd21);
        busy(2'b01, 5'd22, 5'd0);
        check("T6 pend before reset", pend, 3);
        wb_we = 1'b0; rep_v = 2'b00;
        #2;
        check("T6 draining", rf_we, 1'b1);
        rst = 1'b1;
        #1;
        check("T6 we cut", rf_we, 1'b0);
        check("T6 pend cleared", pend, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_age = 0; m_stall = 1'b0; m_drop = 1'b0;
        check("T6 stall", stall, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("T6 no write", s_we, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
